apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   Single-outstanding APB3 requester. Converts a core-side valid/ready request into one
//   APB SETUP/ACCESS transfer and returns read data and error through a valid/ready response.
//   Sits between the core's peripheral port and the APB slaves (CLINT, UART, GPIO).
//   A watchdog aborts transfers whose slave never asserts PREADY.
// PARAMETERS
//   APB_ADDR_WIDTH  12   width of req_addr_i / PADDR
//   TIMEOUT_CYCLES  255  max consecutive PREADY-low ACCESS cycles before abort; 0 = no timeout
// PORTS
//   PCLK         in   1               APB clock; all logic on posedge
//   PRESETn      in   1               asynchronous, active-low reset
//   req_valid_i  in   1               request valid
//   req_ready_o  out  1               request accepted when valid&ready
//   req_addr_i   in   APB_ADDR_WIDTH  byte address
//   req_wdata_i  in   32              write data
//   req_write_i  in   1               1 = write, 0 = read
//   rsp_valid_o  out  1               response valid
//   rsp_ready_i  in   1               response consumed when valid&ready
//   rsp_rdata_o  out  32              read data; 0 for writes and timeouts
//   rsp_err_o    out  1               PSLVERR captured, or timeout
//   PADDR        out  APB_ADDR_WIDTH  APB address
//   PWDATA       out  32              APB write data
//   PWRITE       out  1               APB direction
//   PSEL         out  1               APB select
//   PENABLE      out  1               APB enable
//   PRDATA       in   32              APB read data
//   PREADY       in   1               APB ready
//   PSLVERR      in   1               APB slave error
// BEHAVIOUR
//   - Reset: state IDLE; PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0; rsp_valid_o, rsp_err_o = 0;
//     rsp_rdata_o = 0; wait counter = 0. All APB and rsp outputs are registered.
//   - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. req_ready_o = (state==IDLE), combinational.
//   - IDLE: on req_valid_i, latch addr/wdata/write into PADDR/PWDATA/PWRITE; go to SETUP.
//   - SETUP (1 cycle): PSEL=1, PENABLE=0; clear wait counter; go to ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE stable.
//     - On PREADY=1: rsp_err <= PSLVERR; rsp_rdata <= PWRITE ? 0 : PRDATA.
//       Next cycle: PSEL=0, PENABLE=0, state RESP.
//     - On PREADY=0: counter++. If TIMEOUT_CYCLES!=0 and this is the TIMEOUT_CYCLES-th
//       consecutive low sample: abort with rsp_err=1, rsp_rdata=0, PSEL/PENABLE drop next cycle,
//       state RESP. If PREADY=1 on the limit cycle, the transfer completes normally.
//   - Counter width: $clog2(TIMEOUT_CYCLES+1); saturates and never wraps.
//   - RESP: rsp_valid_o=1 with rdata/err held stable until rsp_ready_i; then IDLE.
//     No new request is accepted before IDLE.
//   - After a transfer, PADDR/PWDATA/PWRITE keep their last values. PENABLE is never 1 while PSEL is 0.
//   - Latency with a zero-wait slave: accept at cycle T, PSEL at T+1, PENABLE at T+2,
//     rsp_valid_o at T+3. Minimum issue interval is 4 cycles.
//   - Reset mid-transfer: PSEL/PENABLE drop asynchronously and any pending response is discarded.
// TESTING
//   1. Zero-wait write addr 0x004, data 0x0000_0100 -> PSEL at T+1, PENABLE at T+2,
//      rsp_valid at T+3 with err=0 and rdata=0.
//   2. Read 0x000 with 3 wait states, PRDATA=0xDEADBEEF -> rsp_rdata=0xDEADBEEF at T+6;
//      PADDR stable through all ACCESS cycles.
//   3. Read with PSLVERR=1, PRDATA=0x1234 -> rsp_err=1, rsp_rdata=0x1234.
//   4. TIMEOUT_CYCLES=4, PREADY tied 0 -> abort after 4 ACCESS cycles; err=1, rdata=0;
//      PSEL low the next cycle. Variant: PREADY=1 on the 4th cycle -> normal completion.
//   5. rsp_ready_i held 0 for 5 cycles with req_valid_i=1 -> rsp_valid, rdata and err stable;
//      req_ready_o=0; the second request is accepted in the cycle after the response handshake.
//   6. PRESETn low during ACCESS -> PSEL=PENABLE=rsp_valid_o=0 immediately;
//      req_ready_o=1 after reset release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 requester: one core request becomes one SETUP/ACCESS transfer,
// and the result returns through a response channel. A watchdog aborts stalled transfers.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic [1:0]                dbg_state_o
);

  // Handshakes: a transfer happens on a rising PCLK edge where valid and ready are both 1;
  // once raised, valid and its payload stay stable until that edge.

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          paddr_d   = req_addr_i;
          pwdata_d  = req_wdata_i;
          pwrite_d  = req_write_i;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
          state_d     = ST_RESP;
        end else begin
          if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
          // This low sample is the limit-th in a row when the count already holds limit-1.
          if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST)) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a vector table of APB transfers with a cycle-accurate slave,
// plus hand-written sequences for response backpressure and reset during ACCESS.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [1:0]  dbg_state;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_write_i (req_write),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        write;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          ready_cycle;  // ACCESS cycle index where PREADY rises; 255 = never
    logic [31:0] prdata;
    logic        slverr;
    int          exp_access;   // ACCESS cycles before the response appears
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur_vec = -1;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got 0x%08h expected 0x%08h", name, cur_vec, act, exp);
    end
  endtask

  task automatic check_rsp(input string name);
    logic [32:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s (vec %0d): response with empty expected queue, got 0x%08h", name, cur_vec, rsp_rdata);
    end else begin
      n_tests--;
      e = exp_q.pop_front();
      check({name, "_rdata"}, rsp_rdata, e[31:0]);
      check({name, "_err"}, {31'h0, rsp_err}, {31'h0, e[32]});
    end
  endtask

  // driver: one full request/response through the table-driven slave model
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    cur_vec = idx;
    @(posedge PCLK); #1;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_write = v.write;
    rsp_ready = 1'b1;
    PREADY    = 1'b0;
    PRDATA    = v.prdata;
    PSLVERR   = v.slverr;
    @(negedge PCLK);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    check("psel_idle", {31'h0, PSEL}, 32'h0);
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    req_addr  = 12'h0;
    req_wdata = 32'h0;
    req_write = 1'b0;
    @(negedge PCLK);
    check("setup_psel_penable", {30'h0, PSEL, PENABLE}, 32'h2);
    check("setup_paddr", {20'h0, PADDR}, {20'h0, v.addr});
    check("setup_pwrite", {31'h0, PWRITE}, {31'h0, v.write});
    check("setup_pwdata", PWDATA, v.wdata);
    for (int i = 0; i < v.exp_access; i++) begin
      @(posedge PCLK); #1;
      PREADY = (i == v.ready_cycle);
      @(negedge PCLK);
      check("access_psel_penable", {30'h0, PSEL, PENABLE}, 32'h3);
      check("access_paddr", {20'h0, PADDR}, {20'h0, v.addr});
      check("access_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    @(posedge PCLK); #1;
    PREADY  = 1'b0;
    PRDATA  = 32'h0BAD_0BAD;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    check("resp_valid", {31'h0, rsp_valid}, 32'h1);
    check("resp_psel_penable", {30'h0, PSEL, PENABLE}, 32'h0);
    check("resp_req_ready", {31'h0, req_ready}, 32'h0);
    check_rsp("resp");
    check("resp_paddr_held", {20'h0, PADDR}, {20'h0, v.addr});
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("done_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("done_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    //              wr    addr     wdata         rdy  prdata        err  acc  exp_rdata     exp_err
    vecs[0] = '{1'b1, 12'h004, 32'h0000_0100, 0,   32'hFFFF_FFFF, 1'b0, 1, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 12'h000, 32'h1111_1111, 3,   32'hDEAD_BEEF, 1'b0, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 12'h010, 32'h0,         0,   32'h0000_1234, 1'b1, 1, 32'h0000_1234, 1'b1};
    vecs[3] = '{1'b0, 12'h020, 32'h0,         255, 32'hAAAA_5555, 1'b0, 4, 32'h0000_0000, 1'b1};
    vecs[4] = '{1'b1, 12'hFFC, 32'hCAFE_F00D, 2,   32'h7777_7777, 1'b1, 3, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 12'h0A8, 32'h1234_5678, 255, 32'h2222_2222, 1'b0, 4, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 12'h800, 32'h0,         1,   32'h0F0F_0F0F, 1'b0, 2, 32'h0F0F_0F0F, 1'b0};

    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_addr  = 12'h0;
    req_wdata = 32'h0;
    req_write = 1'b0;
    rsp_ready = 1'b0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // reset values
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_psel_penable_pwrite", {29'h0, PSEL, PENABLE, PWRITE}, 32'h0);
    check("rst_paddr", {20'h0, PADDR}, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rsp_valid_err", {30'h0, rsp_valid, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_release_req_ready", {31'h0, req_ready}, 32'h1);

    for (int k = 0; k < NVEC; k++) begin
      run_vec(k);
    end

    // response backpressure with a second request waiting
    cur_vec = 100;
    @(posedge PCLK); #1;
    exp_q.push_back({1'b0, 32'h5A5A_5A5A});
    req_valid = 1'b1;
    req_addr  = 12'h040;
    req_wdata = 32'h0;
    req_write = 1'b0;
    rsp_ready = 1'b0;
    PRDATA    = 32'h5A5A_5A5A;
    PSLVERR   = 1'b0;
    @(posedge PCLK); #1;
    req_addr  = 12'h100;
    req_wdata = 32'h0000_0055;
    req_write = 1'b1;
    @(posedge PCLK); #1;
    PREADY = 1'b1;
    @(posedge PCLK); #1;
    PREADY  = 1'b0;
    PRDATA  = 32'hFFFF_0000;
    PSLVERR = 1'b1;
    @(negedge PCLK);
    check_rsp("bp_first");
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rdata_stable", rsp_rdata, 32'h5A5A_5A5A);
      check("bp_err_stable", {31'h0, rsp_err}, 32'h0);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
      check("bp_psel", {31'h0, PSEL}, 32'h0);
      @(posedge PCLK); #1;
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    check("bp_hs_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("bp_after_hs_req_ready", {31'h0, req_ready}, 32'h1);
    check("bp_after_hs_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge PCLK); #1;
    exp_q.push_back({1'b0, 32'h0});
    req_valid = 1'b0;
    PSLVERR   = 1'b0;
    @(negedge PCLK);
    check("bp_second_psel", {30'h0, PSEL, PENABLE}, 32'h2);
    check("bp_second_paddr", {20'h0, PADDR}, 32'h100);
    check("bp_second_pwdata", PWDATA, 32'h0000_0055);
    check("bp_second_pwrite", {31'h0, PWRITE}, 32'h1);
    @(posedge PCLK); #1;
    PREADY = 1'b1;
    @(negedge PCLK);
    check("bp_second_penable", {30'h0, PSEL, PENABLE}, 32'h3);
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    @(negedge PCLK);
    check("bp_second_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_rsp("bp_second");
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("bp_second_done", {31'h0, rsp_valid}, 32'h0);

    // reset asserted during ACCESS
    cur_vec = 200;
    @(posedge PCLK); #1;
    req_valid = 1'b1;
    req_addr  = 12'h0C0;
    req_write = 1'b0;
    PREADY    = 1'b0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("rstmid_in_access", {30'h0, PSEL, PENABLE}, 32'h3);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rstmid_psel_penable", {30'h0, PSEL, PENABLE}, 32'h0);
    check("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
    check("rstmid_no_rsp", {30'h0, rsp_valid, PSEL}, 32'h0);
    run_vec(6);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
